// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the real-time clock / calendar blocks: field widths,
// bit positions of the TIME/DATE packings, packed structs for those packings,
// and helpers shared with the alarm and setting blocks (days_in_month,
// 12/24-hour conversions).
//
// Configuration macro: RTC_LEAP_YEAR_EN
//   defined   -> February has 29 days when YEAR is a multiple of 4
//   undefined -> February always has 28 days
// -----------------------------------------------------------------------------
package rtc_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 7;

  localparam int TIME_W = 1 + HOUR_W + MIN_W + SEC_W;   // 18
  localparam int DATE_W = YEAR_W + MONTH_W + DAY_W;     // 16

  // TIME packing: {PM, HOUR, MIN, SEC}
  localparam int TIME_SEC_LSB  = 0;
  localparam int TIME_MIN_LSB  = TIME_SEC_LSB + SEC_W;
  localparam int TIME_HOUR_LSB = TIME_MIN_LSB + MIN_W;
  localparam int TIME_PM_BIT   = TIME_HOUR_LSB + HOUR_W;

  // DATE packing: {YEAR, MONTH, DAY}
  localparam int DATE_DAY_LSB   = 0;
  localparam int DATE_MONTH_LSB = DATE_DAY_LSB + DAY_W;
  localparam int DATE_YEAR_LSB  = DATE_MONTH_LSB + MONTH_W;

`ifdef RTC_LEAP_YEAR_EN
  localparam bit LEAP_YEAR_EN = 1'b1;
`else
  localparam bit LEAP_YEAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic              pm;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } rtc_time_t;

  typedef struct packed {
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [DAY_W-1:0]   day;
  } rtc_date_t;

  typedef struct packed {
    logic              pm;
    logic [HOUR_W-1:0] hour;
  } hour12_t;

  // Two-digit year covers 2000-2099, where every multiple of 4 is a leap year.
  function automatic logic [DAY_W-1:0] days_in_month(
    input logic [MONTH_W-1:0] month,
    input logic [YEAR_W-1:0]  year
  );
    logic [DAY_W-1:0] days;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
      4'd2:    days = (LEAP_YEAR_EN && ((year % 7'd4) == 7'd0)) ? 5'd29 : 5'd28;
      default: days = 5'd31;
    endcase
    return days;
  endfunction

  // 24-hour (0..23) -> 12-hour (1..12 + PM flag).
  function automatic hour12_t to_12h(input logic [HOUR_W-1:0] hour24);
    hour12_t h;
    if (hour24 == 5'd0) begin
      h.pm = 1'b0; h.hour = 5'd12;
    end else if (hour24 < 5'd12) begin
      h.pm = 1'b0; h.hour = hour24;
    end else if (hour24 == 5'd12) begin
      h.pm = 1'b1; h.hour = 5'd12;
    end else begin
      h.pm = 1'b1; h.hour = hour24 - 5'd12;
    end
    return h;
  endfunction

  // 12-hour (1..12 + PM flag) -> 24-hour. Caller guarantees hour12 in 1..12.
  function automatic logic [HOUR_W-1:0] from_12h(
    input logic              pm,
    input logic [HOUR_W-1:0] hour12
  );
    if (hour12 == 5'd12) return pm ? 5'd12 : 5'd0;
    else                 return pm ? (hour12 + 5'd12) : hour12;
  endfunction

endpackage

// File: rtl/rtc_calendar_if.sv
// -----------------------------------------------------------------------------
// rtc_calendar_if
// Bus between the setting FSM / display path (master) and rtc_calendar (slave).
//   SET, SET_TIME, SET_DATE : load strobe and packed values to load
//   HOLD                    : freeze prescaler and counters
//   FMT_12H                 : 1 = 12-hour format on SET_TIME and TIME_OUT
//   TIME_OUT, DATE_OUT      : registered current time/date
//   SEC_PULSE, DAY_PULSE    : one-cycle strobes on second / midnight rollover
//   SET_ERR                 : one-cycle strobe when a SET is rejected
// -----------------------------------------------------------------------------
interface rtc_calendar_if;
  import rtc_pkg::*;

  logic              SET;
  logic [TIME_W-1:0] SET_TIME;
  logic [DATE_W-1:0] SET_DATE;
  logic              HOLD;
  logic              FMT_12H;
  logic [TIME_W-1:0] TIME_OUT;
  logic [DATE_W-1:0] DATE_OUT;
  logic              SEC_PULSE;
  logic              DAY_PULSE;
  logic              SET_ERR;

  modport master (
    output SET, SET_TIME, SET_DATE, HOLD, FMT_12H,
    input  TIME_OUT, DATE_OUT, SEC_PULSE, DAY_PULSE, SET_ERR
  );

  modport slave (
    input  SET, SET_TIME, SET_DATE, HOLD, FMT_12H,
    output TIME_OUT, DATE_OUT, SEC_PULSE, DAY_PULSE, SET_ERR
  );
endinterface

// File: rtl/rtc_prescaler.sv
// -----------------------------------------------------------------------------
// rtc_prescaler
// Divides CLK into one TICK every TICK_DIV cycles (TICK_DIV >= 2).
//   CLK, RESETN : clock, synchronous active-low reset
//   CLR         : clear count to 0 (no tick this cycle)
//   HOLD        : freeze count; a tick blocked by HOLD fires after release
//   TICK        : combinational, high in the cycle the count wraps
// -----------------------------------------------------------------------------
module rtc_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic CLR,
  input  logic HOLD,
  output logic TICK
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == CNT_MAX);
  assign TICK     = w_at_max && !HOLD && !CLR;

  // NOTE: synchronous reset -- RESETN is only looked at on the clock edge,
  // so it stays out of the sensitivity list.
  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESETN)    r_cnt <= '0;
    else if (CLR)   r_cnt <= '0;
    else if (!HOLD) r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/rtc_calendar.sv
// -----------------------------------------------------------------------------
// rtc_calendar
// Real-time clock and calendar: seconds, minutes, hours (kept internally as
// 24-hour), day, month and two-digit year, advanced once per second tick.
// Loaded through a validated SET; outputs in 12- or 24-hour format.
//   CLK, RESETN : clock, synchronous active-low reset
//   bus (slave) : SET/SET_TIME/SET_DATE/HOLD/FMT_12H in,
//                 TIME_OUT/DATE_OUT/SEC_PULSE/DAY_PULSE/SET_ERR out
// Parameters: TICK_DIV (CLK cycles per second, >= 2), YEAR_RST (0..99).
// Configuration macro: RTC_LEAP_YEAR_EN (February 29 in years divisible by 4).
// -----------------------------------------------------------------------------
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int YEAR_RST = 16
) (
  input  logic           CLK,
  input  logic           RESETN,
  rtc_calendar_if.slave  bus
);

  localparam logic [YEAR_W-1:0] YEAR_RST_V = YEAR_W'(YEAR_RST);
  localparam logic [DATE_W-1:0] DATE_RST   = {YEAR_RST_V, 4'd1, 5'd1};

  // Counters
  logic [SEC_W-1:0]   r_sec;
  logic [MIN_W-1:0]   r_min;
  logic [HOUR_W-1:0]  r_hour;   // always 0..23
  logic [DAY_W-1:0]   r_day;
  logic [MONTH_W-1:0] r_month;
  logic [YEAR_W-1:0]  r_year;

  // Pulse pipeline: stage 1 aligns with the counter update, the output stage
  // with the output register update.
  logic r_sec_p1, r_day_p1;

  // Output registers
  logic [TIME_W-1:0] r_time_out;
  logic [DATE_W-1:0] r_date_out;
  logic              r_sec_pulse, r_day_pulse, r_set_err;

  rtc_time_t         w_set_time;
  rtc_date_t         w_set_date;
  logic              w_hour_ok;
  logic [HOUR_W-1:0] w_set_hour24;
  logic              w_set_valid;
  logic              w_load;
  logic              w_ps_hold;
  logic              w_tick;
  logic              w_day_roll;
  logic [DAY_W-1:0]  w_dim;
  hour12_t           w_hour12;
  rtc_time_t         w_time_fmt;

  assign w_set_time = rtc_time_t'(bus.SET_TIME);
  assign w_set_date = rtc_date_t'(bus.SET_DATE);

  // SET validation. Year is checked too so the counter never holds > 99.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    w_hour_ok    = 1'b0;
    w_set_hour24 = w_set_time.hour;
    if (bus.FMT_12H) begin
      w_hour_ok    = (w_set_time.hour >= 5'd1) && (w_set_time.hour <= 5'd12);
      w_set_hour24 = from_12h(w_set_time.pm, w_set_time.hour);
    end else begin
      w_hour_ok    = (w_set_time.hour <= 5'd23);
    end
    w_set_valid = (w_set_time.sec <= 6'd59) &&
                  (w_set_time.min <= 6'd59) &&
                  w_hour_ok &&
                  (w_set_date.month >= 4'd1) && (w_set_date.month <= 4'd12) &&
                  (w_set_date.day >= 5'd1) &&
                  (w_set_date.day <= days_in_month(w_set_date.month, w_set_date.year)) &&
                  (w_set_date.year <= 7'd99);
  end

  assign w_load = bus.SET && w_set_valid;
  // Any SET, valid or not, suppresses the tick; a rejected SET also leaves
  // the prescaler where it was.
  assign w_ps_hold = bus.HOLD || bus.SET;

  rtc_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .CLK    (CLK),
    .RESETN (RESETN),
    .CLR    (w_load),
    .HOLD   (w_ps_hold),
    .TICK   (w_tick)
  );

  assign w_dim      = days_in_month(r_month, r_year);
  assign w_day_roll = w_tick && (r_sec == 6'd59) && (r_min == 6'd59) && (r_hour == 5'd23);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_sec   <= '0;
      r_min   <= '0;
      r_hour  <= '0;
      r_day   <= 5'd1;
      r_month <= 4'd1;
      r_year  <= YEAR_RST_V;
    end else if (bus.SET) begin
      if (w_set_valid) begin
        r_sec   <= w_set_time.sec;
        r_min   <= w_set_time.min;
        r_hour  <= w_set_hour24;
        r_day   <= w_set_date.day;
        r_month <= w_set_date.month;
        r_year  <= w_set_date.year;
      end
    end else if (w_tick) begin
      if (r_sec != 6'd59) begin
        r_sec <= r_sec + 1'b1;
      end else begin
        r_sec <= '0;
        if (r_min != 6'd59) begin
          r_min <= r_min + 1'b1;
        end else begin
          r_min <= '0;
          if (r_hour != 5'd23) begin
            r_hour <= r_hour + 1'b1;
          end else begin
            r_hour <= '0;
            if (r_day != w_dim) begin
              r_day <= r_day + 1'b1;
            end else begin
              r_day <= 5'd1;
              if (r_month != 4'd12) begin
                r_month <= r_month + 1'b1;
              end else begin
                r_month <= 4'd1;
                r_year  <= (r_year == 7'd99) ? '0 : r_year + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Display formatting only; internal hour stays 24-hour.
  always_comb begin
    w_hour12       = to_12h(r_hour);
    w_time_fmt     = '0;
    w_time_fmt.sec = r_sec;
    w_time_fmt.min = r_min;
    if (bus.FMT_12H) begin
      w_time_fmt.pm   = w_hour12.pm;
      w_time_fmt.hour = w_hour12.hour;
    end else begin
      w_time_fmt.hour = r_hour;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_sec_p1    <= 1'b0;
      r_day_p1    <= 1'b0;
      r_time_out  <= '0;
      r_date_out  <= DATE_RST;
      r_sec_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
      r_set_err   <= 1'b0;
    end else begin
      r_sec_p1    <= w_tick;
      r_day_p1    <= w_day_roll;
      r_time_out  <= w_time_fmt;
      r_date_out  <= {r_year, r_month, r_day};
      r_sec_pulse <= r_sec_p1;
      r_day_pulse <= r_day_p1;
      r_set_err   <= bus.SET && !w_set_valid;
    end
  end

  assign bus.TIME_OUT  = r_time_out;
  assign bus.DATE_OUT  = r_date_out;
  assign bus.SEC_PULSE = r_sec_pulse;
  assign bus.DAY_PULSE = r_day_pulse;
  assign bus.SET_ERR   = r_set_err;

endmodule

// File: doc/rtc_calendar.md
# rtc_calendar

Parametrised real-time clock and calendar counter for the alarm-clock datapath. It divides CLK into second ticks and keeps seconds, minutes, hours, day, month and two-digit year. Month lengths are correct, leap years are optional, and a runtime 12/24-hour display format is selected by an input. It replaces the fixed-rate time calculator, feeds the display formatter and the alarm comparator, and is loaded from the setting FSM.

## Interface
Parameters:
- TICK_DIV, 100, CLK cycles per second; must be ≥ 2.
- YEAR_RST, 16, year loaded on reset (0..99).

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  reset, synchronous, active-low.
- SET  in  1  one-cycle load strobe for SET_TIME and SET_DATE.
- SET_TIME  in  18  {PM, HOUR[4:0], MIN[5:0], SEC[5:0]}; interpreted per FMT_12H.
- SET_DATE  in  16  {YEAR[6:0], MONTH[3:0], DAY[4:0]}.
- HOLD  in  1  freezes prescaler and counters while high.
- FMT_12H  in  1  1 = 12-hour output/input format, 0 = 24-hour.
- TIME_OUT  out  18  registered current time, same packing as SET_TIME.
- DATE_OUT  out  16  registered current date, same packing as SET_DATE.
- SEC_PULSE  out  1  one-cycle strobe on every second increment.
- DAY_PULSE  out  1  one-cycle strobe on the day increment (midnight rollover).
- SET_ERR  out  1  one-cycle strobe when a SET is rejected.

## Operation
- Internal hour register is always 24-hour (0..23). Other registers: SEC 0..59, MIN 0..59, DAY 1..days_in_month, MONTH 1..12, YEAR 0..99.
- Prescaler counts 0..TICK_DIV-1. A tick occurs when prescaler = TICK_DIV-1, HOLD = 0 and SET = 0. The prescaler wraps to 0 on the tick.
- Tick cascade:
  - SEC increments.
  - At 59, SEC goes to 0 and MIN increments.
  - At MIN 59, HOUR increments.
  - At HOUR 23, HOUR goes to 0, DAY increments and DAY_PULSE fires.
  - At last day of month, DAY goes to 1 and MONTH increments.
  - At MONTH 12, MONTH goes to 1 and YEAR increments.
  - At YEAR 99, YEAR wraps to 0.
- days_in_month: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 28 for February (leap rule under Configuration).
- SET: all fields are validated.
  - Valid: counters load, prescaler clears to 0, no tick that cycle.
  - Invalid: SET_ERR pulses and all state is unchanged.
  - Invalid means any of: SEC > 59, MIN > 59, MONTH outside 1..12, DAY outside 1..days_in_month(SET month, SET year), or an hour out of range for the format.
  - 24h input: HOUR 0..23; PM ignored.
  - 12h input: HOUR 1..12. 12 AM → 0, 12 PM → 12, h PM → h+12.
- Output format:
  - 24h: PM bit = 0, HOUR = internal hour.
  - 12h: internal 0 → 12 AM; 1..11 → AM; 12 → 12 PM; 13..23 → hour-12, PM.
  - FMT_12H changes take effect on the next output register update and never alter internal state.
- Priority: RESETN > SET > HOLD > tick.

## Timing
- Reset (RESETN = 0 at a CLK edge): counters go to 00:00:00, day 1, month 1, year YEAR_RST; prescaler 0.
- Output values during reset: TIME_OUT = 18'h0; DATE_OUT = {YEAR_RST, 4'd1, 5'd1}; SEC_PULSE = DAY_PULSE = SET_ERR = 0.
- The first cycle after reset shows the formatted time (12:00:00 AM if FMT_12H = 1).
- Counters update on the tick edge. TIME_OUT/DATE_OUT show the new value 1 cycle later.
- SEC_PULSE and DAY_PULSE are asserted in the same cycle the outputs change.
- SET → loaded value visible on the outputs 2 edges after the SET edge. SET_ERR is asserted 1 cycle after the SET edge.
- Consecutive seconds are exactly TICK_DIV cycles apart while HOLD = 0. HOLD stretches the interval by the number of held cycles. A tick blocked by HOLD occurs on the first cycle after release.
- Reset mid-operation discards any pending tick or set.

## Configuration
- RTC_LEAP_YEAR_EN defined: February has 29 days when YEAR[1:0] = 0 (years 2000–2099). This applies both to rollover and to SET validation.
- RTC_LEAP_YEAR_EN undefined: February always has 28 days, and SET with Feb 29 is rejected.

## Structure
- Package rtc_pkg holds:
  - Field width constants (SEC_W 6, MIN_W 6, HOUR_W 5, DAY_W 5, MONTH_W 4, YEAR_W 7) and the bit positions of the TIME/DATE packings.
  - Function days_in_month(month, year), shared with the alarm and setting blocks.
  - Function to_12h / from_12h hour conversions.
- Sub-module rtc_prescaler (parameter TICK_DIV; inputs CLK, RESETN, CLR, HOLD; output TICK) is factored out and reusable by the blink/buzzer timers.

## Test plan
- SET 23:59:59 24h, date 99-12-31, TICK_DIV = 4 → after 4 cycles TIME_OUT = 00:00:00, DATE_OUT = 00-01-01; SEC_PULSE and DAY_PULSE both pulse once.
- SET 24-02-28 23:59:59, one tick → with RTC_LEAP_YEAR_EN DATE_OUT = 24-02-29; without it DATE_OUT = 24-03-01. Repeat with year 23 → 23-03-01 in both builds.
- SET 30-04-30 23:59:59, one tick → 30-05-01. SET 30-04-31 → SET_ERR = 1 and outputs unchanged.
- Internal 13:05:00 with FMT_12H = 1 → TIME_OUT hour 1, PM 1. Internal 00:30:00 → hour 12, PM 0. SET 12h 12 AM → internal hour 0.
- HOLD high for 10 cycles spanning a tick → the next SEC_PULSE arrives exactly TICK_DIV + 10 cycles after the previous one.
- SET and a tick in the same cycle → loaded value wins, no SEC_PULSE, and the next pulse comes TICK_DIV cycles later. RESETN asserted mid-count → outputs at reset values the next cycle.
